// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-Stream CRC generator.
// Contents:
//   - CRC-32/IEEE constants (normal and reflected polynomial, init, final XOR)
//   - pkt_state_e : packet position state {SOP, MID}
//   - crc32_update_beat : byte-wise reflected CRC-32 update over a masked beat
// The update function works on a fixed maximum beat size (MAX_BYTES). Callers
// zero-extend narrower beats and leave the unused keep bits clear.
package axi_stream_pkg;

  localparam int MAX_BYTES = 64;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOR_OUT   = 32'hFFFF_FFFF;

  typedef enum logic {
    SOP = 1'b0,
    MID = 1'b1
  } pkt_state_e;

  // Bytes are folded in ascending order (byte 0 first); bytes whose keep bit
  // is clear are skipped entirely, so they do not disturb the register.
  function automatic logic [31:0] crc32_update_beat(
    input logic [31:0]              crc_in,
    input logic [MAX_BYTES*8-1:0]   data,
    input logic [MAX_BYTES-1:0]     keep
  );
    logic [31:0] c;
    c = crc_in;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (keep[b]) begin
        c = c ^ {24'h0, data[8*b +: 8]};
        for (int i = 0; i < 8; i++) begin
          c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/axi_stream_skid_buffer.sv
// Two-entry skid buffer for an AXI-Stream beat plus a generic sideband.
// One cycle of latency, full throughput, and s_tready comes straight from a
// flop so no combinational path runs from m_tready to s_tready.
// Ports:
//   clk, srst                      clock, asynchronous active-high reset
//   s_tdata/s_tkeep/s_tlast/s_sb   incoming beat and its sideband
//   s_tvalid / s_tready            source handshake
//   m_tdata/m_tkeep/m_tlast/m_sb   registered beat and sideband
//   m_tvalid / m_tready            sink handshake
// Handshake: a beat moves on a side only at a rising clk edge where that
// side's tvalid and tready are both 1; m_* hold steady while m_tvalid=1 and
// m_tready=0, and s_tready is 1 exactly when the skid entry is empty (after
// the first edge out of reset).
module axi_stream_skid_buffer #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_BYTES = DATA_WIDTH / 8,
  parameter int SB_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_BYTES-1:0] s_tkeep,
  input  logic                  s_tlast,
  input  logic [SB_WIDTH-1:0]   s_sb,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_BYTES-1:0] m_tkeep,
  output logic                  m_tlast,
  output logic [SB_WIDTH-1:0]   m_sb,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  localparam int PW = DATA_WIDTH + KEEP_BYTES + 1 + SB_WIDTH;

  logic [PW-1:0] in_pay;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d;
  logic          main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic          ready_q;
  logic          in_fire;

  assign in_pay  = {s_sb, s_tlast, s_tkeep, s_tdata};
  assign in_fire = s_tvalid & ready_q;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || m_tready) begin
      // Output slot frees up: the skid entry (older) goes first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) main_d = in_pay;
      end
    end else if (in_fire) begin
      // Output stalled: the beat accepted on the registered ready parks here.
      skid_d       = in_pay;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign s_tready = ready_q;
  assign m_tvalid = main_valid_q;
  assign {m_sb, m_tlast, m_tkeep, m_tdata} = main_q;

endmodule

// File: rtl/axi_stream_crc_gen.sv
// AXI-Stream pass-through that computes a CRC-32/IEEE (reflected) per packet
// and presents it, with the packet byte count, on the packet's last beat.
// Ports:
//   clk, srst                     clock, asynchronous active-high reset
//   i_s_tdata/tkeep/tlast         source beat (byte n = bits [8n+7:8n])
//   i_s_tvalid / o_s_tready       source handshake
//   o_m_tdata/tkeep/tlast         registered copy of the source beat
//   o_m_tvalid / i_m_tready       sink handshake
//   o_crc                         {valid, crc[CRC_WIDTH-1:0]}, nonzero on tlast beats only
//   o_byte_count                  saturating packet byte count, tlast beats only
//   o_err                         keep error on the current output beat
// Handshake: a beat moves on a side only at a rising clk edge where that
// side's tvalid and tready are both 1.
// The CRC and count are computed on the input side as a beat is accepted and
// travel with the beat through the skid buffer as sideband, so they are
// aligned with the output beat by construction.
module axi_stream_crc_gen
  import axi_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_BYTES = DATA_WIDTH / 8,
  parameter int CRC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] i_s_tdata,
  input  logic [KEEP_BYTES-1:0] i_s_tkeep,
  input  logic                  i_s_tlast,
  input  logic                  i_s_tvalid,
  output logic                  o_s_tready,
  output logic [DATA_WIDTH-1:0] o_m_tdata,
  output logic [KEEP_BYTES-1:0] o_m_tkeep,
  output logic                  o_m_tlast,
  output logic                  o_m_tvalid,
  input  logic                  i_m_tready,
  output logic [CRC_WIDTH:0]    o_crc,
  output logic [15:0]           o_byte_count,
  output logic                  o_err
);

  localparam int CNT_W = 16;
  localparam int SB_W  = 1 + CNT_W + CRC_WIDTH + 1;
  localparam logic [KEEP_BYTES-1:0] KEEP_ONE = {{(KEEP_BYTES-1){1'b0}}, 1'b1};
  localparam logic [KEEP_BYTES-1:0] KEEP_ALL = '1;

  pkt_state_e                 state_q, state_d;
  logic [31:0]                acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                       in_fire;
  logic [MAX_BYTES*8-1:0]     data_ext;
  logic [MAX_BYTES-1:0]       keep_ext;
  logic [31:0]                seed, crc_next;
  logic [CNT_W-1:0]           pop, cnt_base, cnt_sat;
  logic [CNT_W:0]             cnt_sum;
  logic                       keep_contig, err;
  logic [SB_W-1:0]            sb_in, sb_out;

  assign in_fire = i_s_tvalid & o_s_tready;

  always_comb begin : crc_path
    data_ext = '0;
    data_ext[DATA_WIDTH-1:0] = i_s_tdata;
    keep_ext = '0;
    keep_ext[KEEP_BYTES-1:0] = i_s_tkeep;
    // Every SOP beat starts from init, so nothing carries between packets.
    seed     = (state_q == SOP) ? CRC_INIT : acc_q;
    crc_next = crc32_update_beat(seed, data_ext, keep_ext);

    pop = '0;
    for (int b = 0; b < KEEP_BYTES; b++) pop = pop + {{(CNT_W-1){1'b0}}, i_s_tkeep[b]};
    cnt_base = (state_q == SOP) ? '0 : cnt_q;
    cnt_sum  = {1'b0, cnt_base} + {1'b0, pop};
    cnt_sat  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    // A run of ones from bit 0 turns into a single carry when incremented,
    // so AND-ing with keep+1 is zero exactly for contiguous masks (and 0).
    keep_contig = ((i_s_tkeep & (i_s_tkeep + KEEP_ONE)) == '0);
    err = !keep_contig
          || (!i_s_tlast && (i_s_tkeep != KEEP_ALL))
          || (i_s_tlast && (i_s_tkeep == '0));

    // An empty packet leaves the register at init, and init ^ xorout is 0.
    sb_in = '0;
    sb_in[SB_W-1] = err;
    if (i_s_tlast) begin
      sb_in[CRC_WIDTH:0]                   = {1'b1, crc_next ^ CRC_XOR_OUT};
      sb_in[CRC_WIDTH+CNT_W:CRC_WIDTH+1]   = cnt_sat;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (in_fire) begin
      if (i_s_tlast) begin
        state_d = SOP;
        acc_d   = CRC_INIT;
        cnt_d   = '0;
      end else begin
        state_d = MID;
        acc_d   = crc_next;
        cnt_d   = cnt_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge srst) begin : fsm_reg
    if (srst) begin
      state_q <= SOP;
      acc_q   <= CRC_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  axi_stream_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_BYTES (KEEP_BYTES),
    .SB_WIDTH   (SB_W)
  ) u_skid (
    .clk      (clk),
    .srst     (srst),
    .s_tdata  (i_s_tdata),
    .s_tkeep  (i_s_tkeep),
    .s_tlast  (i_s_tlast),
    .s_sb     (sb_in),
    .s_tvalid (i_s_tvalid),
    .s_tready (o_s_tready),
    .m_tdata  (o_m_tdata),
    .m_tkeep  (o_m_tkeep),
    .m_tlast  (o_m_tlast),
    .m_sb     (sb_out),
    .m_tvalid (o_m_tvalid),
    .m_tready (i_m_tready)
  );

  assign o_err        = sb_out[SB_W-1];
  assign o_byte_count = sb_out[CRC_WIDTH+CNT_W:CRC_WIDTH+1];
  assign o_crc        = sb_out[CRC_WIDTH:0];

endmodule
